seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed hexadecimal display driver for the ULA result path. It latches a DIGITS-wide nibble vector on a load strobe and scans it across a common-segment 7-segment bank: one digit per refresh slot, with dead-time between slots to suppress ghosting. It also provides leading-zero blanking, per-digit decimal points and selectable output polarity. It replaces per-digit combinational decoders once results exceed one digit.

---
 rtl/seg7_scan_driver.sv | 200 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed hexadecimal driver for a common-segment 7-segment bank.
// A DIGITS-wide nibble vector and per-digit decimal points are latched on a
// load strobe, then scanned one digit per refresh slot. The first DEAD cycles
// of every slot keep all digit enables off so the previous digit's segment
// pattern can never ghost onto the next one. Leading zero digits can be
// suppressed, and all display outputs can be driven active-low or
// active-high.
//
// Parameters
//   DIGITS        number of scanned digits (>= 1)
//   REFRESH_DIV   clock cycles per digit slot (>= 2)
//   DEAD          off cycles at the start of every slot (0 <= DEAD < REFRESH_DIV)
//   ACTIVE_LOW    1: segments/dp/digit_en active-low, 0: active-high
//   LEADING_BLANK 1: suppress leading zero digits
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load        in   capture value/dp_in on this rising edge
//   value       in   4*DIGITS nibbles, digit 0 is least significant
//   dp_in       in   decimal point request per digit
//   blank       in   level, forces every display output to its off state
//   segments    out  bit6=a ... bit0=g, registered
//   dp          out  decimal point of the active digit, registered
//   digit_en    out  one-hot digit select or all off, registered
//   frame_done  out  one-cycle active-high pulse when the last digit's slot ends
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
   parameter int DIGITS        = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int DEAD          = 2,
   parameter int ACTIVE_LOW    = 1,
   parameter int LEADING_BLANK = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank,
   output logic [6:0]            segments,
   output logic                  dp,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_done
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
   localparam logic [DIV_W-1:0] DEAD_END = DIV_W'(DEAD);

   // Polarity mask: XOR-ing a logical value with this gives the pin value.
   localparam logic POL = (ACTIVE_LOW != 0);

   localparam logic [6:0]        SEG_OFF = {7{POL}};
   localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{POL}};

   // -----------------------------------------------------------------------
   // Registers
   // -----------------------------------------------------------------------
   logic [4*DIGITS-1:0] r_valQ;
   logic [DIGITS-1:0]   r_dpQ;
   logic [DIV_W-1:0]    r_div;
   logic [IDX_W-1:0]    r_idx;

   logic [6:0]          r_segments;
   logic                r_dp;
   logic [DIGITS-1:0]   r_digitEn;
   logic                r_frameDone;

   // -----------------------------------------------------------------------
   // Combinational helpers
   // -----------------------------------------------------------------------
   logic [3:0]          w_nibble [DIGITS];
   logic [DIGITS-1:0]   w_blankMask;
   logic                w_zeroAbove;
   logic                w_dpAbove;
   logic                w_slotEnd;
   logic                w_frameEnd;
   logic                w_inDead;
   logic                w_off;
   logic [3:0]          w_curNibble;
   logic [6:0]          w_glyph;
   logic [6:0]          w_segLogic;
   logic                w_dpLogic;
   logic [DIGITS-1:0]   w_enLogic;

   // Logical (active-high) glyph for one hex nibble, bit6=a ... bit0=g.
   function automatic logic [6:0] glyphOf(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'b1111110;
         4'h1:    g = 7'b0110000;
         4'h2:    g = 7'b1101101;
         4'h3:    g = 7'b1111001;
         4'h4:    g = 7'b0110011;
         4'h5:    g = 7'b1011011;
         4'h6:    g = 7'b1011111;
         4'h7:    g = 7'b1110000;
         4'h8:    g = 7'b1111111;
         4'h9:    g = 7'b1111011;
         4'hA:    g = 7'b1110111;
         4'hB:    g = 7'b0011111;
         4'hC:    g = 7'b1001110;
         4'hD:    g = 7'b0111101;
         4'hE:    g = 7'b1001111;
         default: g = 7'b1000111;
      endcase
      return g;
   endfunction

   for (genvar g = 0; g < DIGITS; g++) begin : g_nibble
      assign w_nibble[g] = r_valQ[4*g +: 4];
   end

   // Walk from the most significant digit down: a digit is a leading zero
   // while every nibble at or above it is zero, unless a decimal point is
   // requested at or above it (a dp must stay visible, and so must the
   // digits below it, e.g. "0.05").
   always_comb begin
      w_blankMask = '0;
      w_zeroAbove = 1'b1;
      w_dpAbove   = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zeroAbove    = w_zeroAbove & (w_nibble[i] == 4'h0);
         w_dpAbove      = w_dpAbove | r_dpQ[i];
         w_blankMask[i] = (LEADING_BLANK != 0) && (i != 0) && w_zeroAbove && !w_dpAbove;
      end
   end

   assign w_slotEnd   = (r_div == DIV_LAST);
   assign w_frameEnd  = w_slotEnd && (r_idx == IDX_LAST);
   assign w_inDead    = (DEAD > 0) && (r_div < DEAD_END);

   assign w_off       = blank | w_inDead | w_blankMask[r_idx];
   assign w_curNibble = w_nibble[r_idx];
   assign w_glyph     = glyphOf(w_curNibble);

   assign w_segLogic  = w_off ? 7'h00 : w_glyph;
   assign w_dpLogic   = w_off ? 1'b0  : r_dpQ[r_idx];
   assign w_enLogic   = w_off ? '0    : (DIGITS'(1) << r_idx);

   // -----------------------------------------------------------------------
   // Display value latch. A new load simply overwrites the previous one.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valQ <= '0;
         r_dpQ  <= '0;
      end else if (load) begin
         r_valQ <= value;
         r_dpQ  <= dp_in;
      end
   end

   // -----------------------------------------------------------------------
   // Scan counters. They free-run regardless of blank so that releasing
   // blank resumes in the correct phase.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_idx <= '0;
      end else if (w_slotEnd) begin
         r_div <= '0;
         r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
         r_div <= r_div + 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Registered outputs, polarity applied before the flops so the pins are
   // glitch-free and reset straight into the off state.
   // -----------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_segments  <= SEG_OFF;
         r_dp        <= POL;
         r_digitEn   <= EN_OFF;
         r_frameDone <= 1'b0;
      end else begin
         r_segments  <= {7{POL}} ^ w_segLogic;
         r_dp        <= POL ^ w_dpLogic;
         r_digitEn   <= {DIGITS{POL}} ^ w_enLogic;
         r_frameDone <= w_frameEnd;
      end
   end

   assign segments   = r_segments;
   assign dp         = r_dp;
   assign digit_en   = r_digitEn;
   assign frame_done = r_frameDone;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed testbench for seg7_scan_driver with DIGITS=4, REFRESH_DIV=4,
// DEAD=1, ACTIVE_LOW=1, LEADING_BLANK=1. A frame is 16 cycles; phase p of a
// frame is digit p/4, slot cycle p%4 (cycle 0 is the dead cycle). The bench
// counts edges since reset release in cyc; the registered outputs seen after
// edge n reflect scan phase n-1.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic        blank;
   logic [6:0]  segments;
   logic        dp;
   logic [3:0]  digit_en;
   logic        frame_done;

   int nCompared;
   int nMismatched;
   int cyc;

   seg7_scan_driver #(
      .DIGITS       (4),
      .REFRESH_DIV  (4),
      .DEAD         (1),
      .ACTIVE_LOW   (1),
      .LEADING_BLANK(1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .value     (value),
      .dp_in     (dp_in),
      .blank     (blank),
      .segments  (segments),
      .dp        (dp),
      .digit_en  (digit_en),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Advance until the next tick shows phase 0 of a frame.
   task automatic waitFrameStart();
      for (int k = 0; k < 16 && (cyc % 16) != 0; k++) tick();
   endtask

   // Present a value for exactly one load edge.
   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d);
      value = v;
      dp_in = d;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      nCompared++;
      if ({digit_en, segments, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL reset_hold: got en=%h seg=%h dp=%b fd=%b, want en=f seg=7f dp=1 fd=0",
                  digit_en, segments, dp, frame_done);
      end
      rst_n = 1'b1;
      cyc   = 0;
      tick();
      nCompared++;
      if ({digit_en, segments, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL reset_dead: got en=%h seg=%h dp=%b fd=%b, want en=f seg=7f dp=1 fd=0",
                  digit_en, segments, dp, frame_done);
      end
      tick();
      nCompared++;
      if ({digit_en, segments, dp, frame_done} !== {4'hE, 7'h01, 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL reset_first_digit: got en=%h seg=%h dp=%b fd=%b, want en=e seg=01 dp=1 fd=0",
                  digit_en, segments, dp, frame_done);
      end
   endtask

   task automatic test_scan_value();
      logic [6:0] segTab [4];
      logic [3:0] enTab  [4];
      logic [6:0] expSeg;
      logic [3:0] expEn;
      segTab = '{7'h01, 7'h08, 7'h12, 7'h4F};
      enTab  = '{4'hE, 4'hD, 4'hB, 4'h7};
      applyStimulus(16'h12A0, 4'b0000);
      waitFrameStart();
      for (int p = 0; p < 16; p++) begin
         tick();
         expEn  = (p % 4 == 0) ? 4'hF  : enTab[p / 4];
         expSeg = (p % 4 == 0) ? 7'h7F : segTab[p / 4];
         nCompared++;
         if ({digit_en, segments, dp, frame_done} !== {expEn, expSeg, 1'b1, (p == 15)}) begin
            nMismatched++;
            $display("[TB] FAIL scan_12A0 p=%0d: got en=%h seg=%h dp=%b fd=%b, want en=%h seg=%h dp=1 fd=%b",
                     p, digit_en, segments, dp, frame_done, expEn, expSeg, (p == 15));
         end
      end
   endtask

   task automatic test_leading_blank();
      logic [6:0] segTab [4];
      logic [3:0] enTab  [4];
      logic       dpTab  [4];
      logic [6:0] expSeg;
      logic [3:0] expEn;
      logic       expDp;
      // 0050, no dp: digits 3 and 2 are leading zeros.
      segTab = '{7'h01, 7'h24, 7'h7F, 7'h7F};
      enTab  = '{4'hE, 4'hD, 4'hF, 4'hF};
      dpTab  = '{1'b1, 1'b1, 1'b1, 1'b1};
      applyStimulus(16'h0050, 4'b0000);
      waitFrameStart();
      for (int p = 0; p < 16; p++) begin
         tick();
         expEn  = (p % 4 == 0) ? 4'hF  : enTab[p / 4];
         expSeg = (p % 4 == 0) ? 7'h7F : segTab[p / 4];
         expDp  = (p % 4 == 0) ? 1'b1  : dpTab[p / 4];
         nCompared++;
         if ({digit_en, segments, dp, frame_done} !== {expEn, expSeg, expDp, (p == 15)}) begin
            nMismatched++;
            $display("[TB] FAIL blank_0050 p=%0d: got en=%h seg=%h dp=%b fd=%b, want en=%h seg=%h dp=%b fd=%b",
                     p, digit_en, segments, dp, frame_done, expEn, expSeg, expDp, (p == 15));
         end
      end
      // dp on digit 2 un-blanks it: "0.50" style, digit 3 stays dark.
      segTab = '{7'h01, 7'h24, 7'h01, 7'h7F};
      enTab  = '{4'hE, 4'hD, 4'hB, 4'hF};
      dpTab  = '{1'b1, 1'b1, 1'b0, 1'b1};
      applyStimulus(16'h0050, 4'b0100);
      waitFrameStart();
      for (int p = 0; p < 16; p++) begin
         tick();
         expEn  = (p % 4 == 0) ? 4'hF  : enTab[p / 4];
         expSeg = (p % 4 == 0) ? 7'h7F : segTab[p / 4];
         expDp  = (p % 4 == 0) ? 1'b1  : dpTab[p / 4];
         nCompared++;
         if ({digit_en, segments, dp, frame_done} !== {expEn, expSeg, expDp, (p == 15)}) begin
            nMismatched++;
            $display("[TB] FAIL dp_unblank p=%0d: got en=%h seg=%h dp=%b fd=%b, want en=%h seg=%h dp=%b fd=%b",
                     p, digit_en, segments, dp, frame_done, expEn, expSeg, expDp, (p == 15));
         end
      end
   endtask

   task automatic test_blank();
      logic [3:0] expEn;
      logic [6:0] expSeg;
      logic       expDp;
      // Display holds 0050 with dp on digit 2.
      waitFrameStart();
      repeat (5) tick();
      blank = 1'b1;
      for (int p = 5; p < 11; p++) begin
         tick();
         nCompared++;
         if ({digit_en, segments, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL blank_on p=%0d: got en=%h seg=%h dp=%b fd=%b, want en=f seg=7f dp=1 fd=0",
                     p, digit_en, segments, dp, frame_done);
         end
      end
      blank = 1'b0;
      for (int p = 11; p < 16; p++) begin
         tick();
         expEn  = (p == 11) ? 4'hB  : 4'hF;
         expSeg = (p == 11) ? 7'h01 : 7'h7F;
         expDp  = (p == 11) ? 1'b0  : 1'b1;
         nCompared++;
         if ({digit_en, segments, dp, frame_done} !== {expEn, expSeg, expDp, (p == 15)}) begin
            nMismatched++;
            $display("[TB] FAIL blank_resume p=%0d: got en=%h seg=%h dp=%b fd=%b, want en=%h seg=%h dp=%b fd=%b",
                     p, digit_en, segments, dp, frame_done, expEn, expSeg, expDp, (p == 15));
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] expEn;
      logic [6:0] expSeg;
      applyStimulus(16'h12A0, 4'b0000);
      waitFrameStart();
      repeat (10) tick();
      nCompared++;
      if ({digit_en, segments} !== {4'hB, 7'h12}) begin
         nMismatched++;
         $display("[TB] FAIL pre_reset_digit2: got en=%h seg=%h, want en=b seg=12", digit_en, segments);
      end
      #3;
      rst_n = 1'b0;
      #1;
      nCompared++;
      if ({digit_en, segments, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         nMismatched++;
         $display("[TB] FAIL async_reset: got en=%h seg=%h dp=%b fd=%b, want en=f seg=7f dp=1 fd=0",
                  digit_en, segments, dp, frame_done);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      // Value cleared: digit 0 shows '0', digit 1 is a blanked leading zero.
      for (int p = 0; p < 8; p++) begin
         tick();
         expEn  = (p >= 1 && p <= 3) ? 4'hE  : 4'hF;
         expSeg = (p >= 1 && p <= 3) ? 7'h01 : 7'h7F;
         nCompared++;
         if ({digit_en, segments, dp, frame_done} !== {expEn, expSeg, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL restart p=%0d: got en=%h seg=%h dp=%b fd=%b, want en=%h seg=%h dp=1 fd=0",
                     p, digit_en, segments, dp, frame_done, expEn, expSeg);
         end
      end
   endtask

   task automatic test_load_timing();
      // Load coinciding with the digit 0 -> 1 slot boundary.
      waitFrameStart();
      repeat (3) tick();
      applyStimulus(16'h0090, 4'b0000);
      nCompared++;
      if ({digit_en, segments} !== {4'hE, 7'h01}) begin
         nMismatched++;
         $display("[TB] FAIL boundary_old: got en=%h seg=%h, want en=e seg=01", digit_en, segments);
      end
      tick();
      nCompared++;
      if ({digit_en, segments} !== {4'hF, 7'h7F}) begin
         nMismatched++;
         $display("[TB] FAIL boundary_dead: got en=%h seg=%h, want en=f seg=7f", digit_en, segments);
      end
      tick();
      nCompared++;
      if ({digit_en, segments, dp} !== {4'hD, 7'h04, 1'b1}) begin
         nMismatched++;
         $display("[TB] FAIL boundary_new: got en=%h seg=%h dp=%b, want en=d seg=04 dp=1",
                  digit_en, segments, dp);
      end
      // Load mid-slot: glyph changes two edges after the load edge's launch.
      waitFrameStart();
      repeat (2) tick();
      applyStimulus(16'h0097, 4'b0000);
      nCompared++;
      if ({digit_en, segments} !== {4'hE, 7'h01}) begin
         nMismatched++;
         $display("[TB] FAIL latency_old: got en=%h seg=%h, want en=e seg=01", digit_en, segments);
      end
      tick();
      nCompared++;
      if ({digit_en, segments} !== {4'hE, 7'h0F}) begin
         nMismatched++;
         $display("[TB] FAIL latency_new: got en=%h seg=%h, want en=e seg=0f", digit_en, segments);
      end
   endtask

   task automatic test_frame_timing();
      int pulses;
      int lastFd;
      int firstFd;
      int spaceBad;
      int multiHot;
      pulses   = 0;
      lastFd   = -1;
      firstFd  = -1;
      spaceBad = 0;
      multiHot = 0;
      waitFrameStart();
      for (int k = 0; k < 48; k++) begin
         tick();
         if (frame_done === 1'b1) begin
            pulses++;
            if (lastFd < 0) firstFd = k;
            else if (k - lastFd != 16) spaceBad++;
            lastFd = k;
         end
         if (!(digit_en inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF})) multiHot++;
      end
      nCompared++;
      if (pulses != 3) begin
         nMismatched++;
         $display("[TB] FAIL fd_count: got %0d, want 3", pulses);
      end
      nCompared++;
      if (firstFd != 15) begin
         nMismatched++;
         $display("[TB] FAIL fd_first: got %0d, want 15", firstFd);
      end
      nCompared++;
      if (spaceBad != 0) begin
         nMismatched++;
         $display("[TB] FAIL fd_spacing: got %0d bad gaps, want 0", spaceBad);
      end
      nCompared++;
      if (multiHot != 0) begin
         nMismatched++;
         $display("[TB] FAIL en_onehot: got %0d bad cycles, want 0", multiHot);
      end
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      cyc         = 0;
      rst_n       = 1'b0;
      load        = 1'b0;
      value       = '0;
      dp_in       = '0;
      blank       = 1'b0;
      test_reset();
      test_scan_value();
      test_leading_blank();
      test_blank();
      test_mid_reset();
      test_load_timing();
      test_frame_timing();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
